// File: rtl/true_dpr_pkg.sv
// true_dpr_pkg: shared constants for the true_dpr_be RAM
// read-during-write modes, collision priority, counter width
package true_dpr_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  localparam int PRIO_A = 0;
  localparam int PRIO_B = 1;

  localparam int COLL_CNT_W = 16;

endpackage

// File: rtl/true_dpr_be_if.sv
// true_dpr_be_if: both RAM ports plus collision status
// master drives accesses, slave is the RAM
interface true_dpr_be_if
  import true_dpr_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8
);
  localparam int NB = DATA_SIZE / BYTE_SIZE;

  logic                  en_a;
  logic [NB-1:0]         we_a;
  logic [ADDR_SIZE-1:0]  addr_a;
  logic [DATA_SIZE-1:0]  din_a;
  logic [DATA_SIZE-1:0]  dout_a;
  logic                  valid_a;

  logic                  en_b;
  logic [NB-1:0]         we_b;
  logic [ADDR_SIZE-1:0]  addr_b;
  logic [DATA_SIZE-1:0]  din_b;
  logic [DATA_SIZE-1:0]  dout_b;
  logic                  valid_b;

  logic                  coll;
  logic [COLL_CNT_W-1:0] coll_cnt;

  modport master (
    output en_a, we_a, addr_a, din_a,
    output en_b, we_b, addr_b, din_b,
    input  dout_a, valid_a,
    input  dout_b, valid_b,
    input  coll, coll_cnt
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a,
    input  en_b, we_b, addr_b, din_b,
    output dout_a, valid_a,
    output dout_b, valid_b,
    output coll, coll_cnt
  );

endinterface

// File: rtl/true_dpr_port_out.sv
// true_dpr_port_out: per-port read data / valid / collision registers
// TRUE_DPR_OUTREG_EN adds a second register stage
module true_dpr_port_out #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_i,
  input  logic                 coll_i,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic [DATA_SIZE-1:0] dout_o,
  output logic                 valid_o,
  output logic                 coll_o
);

  logic [DATA_SIZE-1:0] dout_d, dout_q;
  logic                 valid_d, valid_q;
  logic                 coll_d, coll_q;

  // dout holds its value on cycles without a returning read
  always_comb begin
    dout_d  = dout_q;
    valid_d = vld_i;
    coll_d  = coll_i;
    if (vld_i) dout_d = data_i;
  end

  // first output stage, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      coll_q  <= coll_d;
    end
  end

`ifdef TRUE_DPR_OUTREG_EN
  logic [DATA_SIZE-1:0] dout2_d, dout2_q;
  logic                 valid2_d, valid2_q;
  logic                 coll2_d, coll2_q;

  // second stage simply delays the first one
  always_comb begin
    dout2_d  = dout_q;
    valid2_d = valid_q;
    coll2_d  = coll_q;
  end

  // extra output register, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout2_q  <= '0;
      valid2_q <= 1'b0;
      coll2_q  <= 1'b0;
    end else begin
      dout2_q  <= dout2_d;
      valid2_q <= valid2_d;
      coll2_q  <= coll2_d;
    end
  end

  assign dout_o  = dout2_q;
  assign valid_o = valid2_q;
  assign coll_o  = coll2_q;
`else
  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign coll_o  = coll_q;
`endif

endmodule

// File: rtl/true_dpr_be.sv
// true_dpr_be: true dual-port RAM, byte enables, collision counter
// TRUE_DPR_OUTREG_EN: read latency 2 instead of 1
module true_dpr_be
  import true_dpr_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int RAM_SIZE  = 1 << ADDR_SIZE,
  parameter int RDW_MODE  = RDW_READ_FIRST,
  parameter int COLL_PRIO = PRIO_A
) (
  input logic          clk,
  input logic          rst_n,
  true_dpr_be_if.slave bus
);

  localparam int NB = DATA_SIZE / BYTE_SIZE;
  localparam int BW = BYTE_SIZE;

  logic [DATA_SIZE-1:0] ram [RAM_SIZE];

  logic [DATA_SIZE-1:0]  old_a, old_b;
  logic [DATA_SIZE-1:0]  mrg_a, mrg_b;
  logic [DATA_SIZE-1:0]  rd_a, rd_b;
  logic [NB-1:0]         lane_a, lane_b;
  logic                  wr_a, wr_b;
  logic                  same, coll_now;
  logic                  vld_a, vld_b;
  logic                  coll_a, coll_b;
  logic [COLL_CNT_W-1:0] cnt_d, cnt_q;

  // write decode; on a shared address the losing port drops shared lanes
  always_comb begin
    wr_a     = rst_n & bus.en_a & (|bus.we_a);
    wr_b     = rst_n & bus.en_b & (|bus.we_b);
    same     = bus.addr_a == bus.addr_b;
    coll_now = bus.en_a & bus.en_b & same
             & ((|bus.we_a) | (|bus.we_b));
    lane_a   = wr_a ? bus.we_a : '0;
    lane_b   = wr_b ? bus.we_b : '0;
    if (same && COLL_PRIO == PRIO_A) lane_b = lane_b & ~lane_a;
    if (same && COLL_PRIO == PRIO_B) lane_a = lane_a & ~lane_b;
  end

  // read word per port: pre-write array word, or own merge if write-first
  always_comb begin
    old_a = ram[bus.addr_a];
    old_b = ram[bus.addr_b];
    mrg_a = old_a;
    mrg_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (bus.we_a[i]) mrg_a[i*BW +: BW] = bus.din_a[i*BW +: BW];
      if (bus.we_b[i]) mrg_b[i*BW +: BW] = bus.din_b[i*BW +: BW];
    end
    rd_a  = old_a;
    rd_b  = old_b;
    vld_a = bus.en_a;
    vld_b = bus.en_b;
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      rd_a = mrg_a;
      rd_b = mrg_b;
    end
    if (RDW_MODE == RDW_NO_CHANGE) begin
      vld_a = bus.en_a & ~(|bus.we_a);
      vld_b = bus.en_b & ~(|bus.we_b);
    end
  end

  // array lane writes; lane masks never overlap on one address
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_a[i])
        ram[bus.addr_a][i*BW +: BW] <= bus.din_a[i*BW +: BW];
      if (lane_b[i])
        ram[bus.addr_b][i*BW +: BW] <= bus.din_b[i*BW +: BW];
    end
  end

  // saturating collision count
  always_comb begin
    cnt_d = cnt_q;
    if (coll_now && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // collision counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  true_dpr_port_out #(
    .DATA_SIZE (DATA_SIZE)
  ) u_out_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   (vld_a),
    .coll_i  (coll_now),
    .data_i  (rd_a),
    .dout_o  (bus.dout_a),
    .valid_o (bus.valid_a),
    .coll_o  (coll_a)
  );

  true_dpr_port_out #(
    .DATA_SIZE (DATA_SIZE)
  ) u_out_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   (vld_b),
    .coll_i  (coll_now),
    .data_i  (rd_b),
    .dout_o  (bus.dout_b),
    .valid_o (bus.valid_b),
    .coll_o  (coll_b)
  );

  assign bus.coll     = coll_a | coll_b;
  assign bus.coll_cnt = cnt_q;

endmodule

// File: tb/tb_true_dpr_be.sv
// tb_true_dpr_be: three RAM configurations against one reference model
// u0 READ_FIRST/prio A, u1 WRITE_FIRST/prio B, u2 NO_CHANGE/prio A
module tb_true_dpr_be;

  localparam int ND = 3;
`ifdef TRUE_DPR_OUTREG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] o_da [ND];
  logic [31:0] o_db [ND];
  logic        o_va [ND];
  logic        o_vb [ND];
  logic        o_c  [ND];
  logic [15:0] o_cnt [ND];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  true_dpr_be_if bus0 ();
  true_dpr_be_if bus1 ();
  true_dpr_be_if bus2 ();

`define TB_BIND(B, K) \
  assign B.en_a = en_a; assign B.we_a = we_a; \
  assign B.addr_a = addr_a; assign B.din_a = din_a; \
  assign B.en_b = en_b; assign B.we_b = we_b; \
  assign B.addr_b = addr_b; assign B.din_b = din_b; \
  assign o_da[K] = B.dout_a; assign o_db[K] = B.dout_b; \
  assign o_va[K] = B.valid_a; assign o_vb[K] = B.valid_b; \
  assign o_c[K] = B.coll; assign o_cnt[K] = B.coll_cnt;

  `TB_BIND(bus0, 0)
  `TB_BIND(bus1, 1)
  `TB_BIND(bus2, 2)

  true_dpr_be #(.RDW_MODE(0), .COLL_PRIO(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  true_dpr_be #(.RDW_MODE(1), .COLL_PRIO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  true_dpr_be #(.RDW_MODE(2), .COLL_PRIO(0)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // reference state: memory image, last two read results, count
  logic [31:0] m_mem [ND][256];
  logic [31:0] r1_d [ND][2];
  logic [31:0] r2_d [ND][2];
  bit          r1_v [ND][2];
  bit          r2_v [ND][2];
  bit          r1_c [ND];
  bit          r2_c [ND];
  int          m_cnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                        logic [3:0] m);
    for (int l = 0; l < 4; l++)
      if (m[l]) o[l*8 +: 8] = n[l*8 +: 8];
    return o;
  endfunction

  function automatic logic [31:0] preval(int a);
    return (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      for (int p = 0; p < 2; p++) begin
        r1_d[k][p] = '0; r2_d[k][p] = '0;
        r1_v[k][p] = 0;  r2_v[k][p] = 0;
      end
      r1_c[k] = 0; r2_c[k] = 0;
    end
    m_cnt = 0;
  endtask

  // one access cycle applied to the reference, config k = mode index
  task automatic model_step();
    bit wa, wb, col, va, vb, ba, bb;
    logic [31:0] oa, ob, w;
    wa  = en_a && we_a != 0;
    wb  = en_b && we_b != 0;
    col = en_a && en_b && addr_a == addr_b && (wa || wb);
    for (int k = 0; k < ND; k++) begin
      oa = m_mem[k][addr_a];
      ob = m_mem[k][addr_b];
      for (int p = 0; p < 2; p++) begin
        r2_d[k][p] = r1_d[k][p];
        r2_v[k][p] = r1_v[k][p];
      end
      r2_c[k] = r1_c[k];
      va = en_a && !(k == 2 && wa);
      vb = en_b && !(k == 2 && wb);
      if (va) r1_d[k][0] = (k == 1) ? merge(oa, din_a, we_a) : oa;
      if (vb) r1_d[k][1] = (k == 1) ? merge(ob, din_b, we_b) : ob;
      r1_v[k][0] = va;
      r1_v[k][1] = vb;
      r1_c[k] = col;
      if (addr_a != addr_b) begin
        if (wa) m_mem[k][addr_a] = merge(oa, din_a, we_a);
        if (wb) m_mem[k][addr_b] = merge(ob, din_b, we_b);
      end else begin
        w = oa;
        for (int l = 0; l < 4; l++) begin
          ba = wa && we_a[l];
          bb = wb && we_b[l];
          if (ba && bb) w[l*8 +: 8] = (k == 1) ? din_b[l*8 +: 8] : din_a[l*8 +: 8];
          else if (ba)  w[l*8 +: 8] = din_a[l*8 +: 8];
          else if (bb)  w[l*8 +: 8] = din_b[l*8 +: 8];
        end
        m_mem[k][addr_a] = w;
      end
    end
    if (col && m_cnt < 65535) m_cnt++;
  endtask

  task automatic check_all();
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("u%0d_dout_a", k), o_da[k], OREG ? r2_d[k][0] : r1_d[k][0]);
      chk($sformatf("u%0d_dout_b", k), o_db[k], OREG ? r2_d[k][1] : r1_d[k][1]);
      chk($sformatf("u%0d_valid_a", k), 32'(o_va[k]),
          32'(OREG ? r2_v[k][0] : r1_v[k][0]));
      chk($sformatf("u%0d_valid_b", k), 32'(o_vb[k]),
          32'(OREG ? r2_v[k][1] : r1_v[k][1]));
      chk($sformatf("u%0d_coll", k), 32'(o_c[k]), 32'(OREG ? r2_c[k] : r1_c[k]));
      chk($sformatf("u%0d_coll_cnt", k), 32'(o_cnt[k]), 32'(m_cnt));
    end
  endtask

  task automatic step(bit do_chk = 1'b1);
    model_step();
    @(posedge clk);
    #1;
    if (do_chk) check_all();
  endtask

  task automatic idle();
    en_a = 0; en_b = 0; we_a = '0; we_b = '0;
  endtask

  // make the latest access visible on the outputs
  task automatic flush();
    idle();
    if (OREG) step();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr_a(logic [7:0] a, logic [31:0] d, logic [3:0] m);
    idle(); en_a = 1; we_a = m; addr_a = a; din_a = d;
  endtask

  task automatic rd_a(logic [7:0] a);
    idle(); en_a = 1; we_a = '0; addr_a = a;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    for (int k = 0; k < ND; k++)
      for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
    do_reset();

    // preload every word, then reset to drop the undefined read results
    for (int a = 0; a < 256; a++) begin
      wr_a(8'(a), preval(a), 4'hF);
      step(1'b0);
    end
    do_reset();

    // write on A, read on B next cycle
    wr_a(8'h10, 32'hDEAD_BEEF, 4'hF); step();
    idle(); en_b = 1; addr_b = 8'h10; step();
    flush();
    for (int k = 0; k < ND; k++)
      chk($sformatf("t1_u%0d_dout_b", k), o_db[k], 32'hDEAD_BEEF);

    // partial write, read-during-write per mode
    wr_a(8'h20, 32'hAABB_CCDD, 4'hF); step();
    rd_a(8'h10); step();
    wr_a(8'h20, 32'h1122_3344, 4'h3); step();
    flush();
    chk("t2_rf_dout_a", o_da[0], 32'hAABB_CCDD);
    chk("t2_wf_dout_a", o_da[1], 32'hAABB_3344);
    chk("t2_nc_dout_a", o_da[2], 32'hDEAD_BEEF);

    // write-write collision
    idle();
    en_a = 1; we_a = 4'hF; addr_a = 8'h30; din_a = 32'h1111_1111;
    en_b = 1; we_b = 4'hC; addr_b = 8'h30; din_b = 32'h2222_2222;
    step();
    flush();
    chk("t3_coll", 32'(o_c[0]), 32'd1);
    rd_a(8'h30); step();
    flush();
    chk("t3_prioa_rd", o_da[0], 32'h1111_1111);
    chk("t3_priob_rd", o_da[1], 32'h2222_1111);
    chk("t3_prioa2_rd", o_da[2], 32'h1111_1111);
    chk("t3_cnt", 32'(o_cnt[0]), 32'd1);

    // cross-port read of an address being written
    wr_a(8'h40, 32'h0000_0099, 4'hF); step();
    wr_a(8'h40, 32'h0000_0055, 4'hF);
    en_b = 1; we_b = '0; addr_b = 8'h40;
    step();
    flush();
    for (int k = 0; k < ND; k++)
      chk($sformatf("t4_u%0d_dout_b", k), o_db[k], 32'h0000_0099);
    chk("t4_coll", 32'(o_c[2]), 32'd1);
    rd_a(8'h40); step();
    flush();
    chk("t4_new_rd", o_da[0], 32'h0000_0055);
    chk("t4_cnt", 32'(o_cnt[1]), 32'd2);

    // async reset during back-to-back reads with a write pending
    idle(); en_a = 1; addr_a = 8'h10; en_b = 1; addr_b = 8'h20; step();
    addr_a = 8'h11; step();
    en_a = 1; we_a = 4'hF; addr_a = 8'h50; din_a = 32'hCAFE_F00D;
    en_b = 1; we_b = '0; addr_b = 8'h11;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    rd_a(8'h50); step();
    flush();
    chk("rst_nowrite", o_da[0], preval(8'h50));

    // random traffic on a small address window
    for (int n = 0; n < 1500; n++) begin
      en_a   = $urandom_range(0, 3) != 0;
      en_b   = $urandom_range(0, 3) != 0;
      we_a   = $urandom_range(0, 1) != 0 ? 4'($urandom_range(0, 15)) : 4'h0;
      we_b   = $urandom_range(0, 1) != 0 ? 4'($urandom_range(0, 15)) : 4'h0;
      addr_a = 8'h60 + 8'($urandom_range(0, 3));
      addr_b = 8'h60 + 8'($urandom_range(0, 3));
      din_a  = $urandom();
      din_b  = $urandom();
      step();
    end

    // counter saturation
    do_reset();
    for (int n = 0; n < 65534; n++) begin
      idle();
      en_a = 1; we_a = 4'hF; addr_a = 8'h70; din_a = $urandom();
      en_b = 1; addr_b = 8'h70;
      step(n >= 65530);
    end
    chk("sat_fffe", 32'(o_cnt[0]), 32'h0000_FFFE);
    step();
    chk("sat_ffff", 32'(o_cnt[1]), 32'h0000_FFFF);
    step();
    for (int k = 0; k < ND; k++)
      chk($sformatf("sat_hold_u%0d", k), 32'(o_cnt[k]), 32'h0000_FFFF);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
